// File: rtl/matmul_host.sv
// -----------------------------------------------------------------------------
// matmul_host
//
// Host-side driver for the matmul subsystem. Accepts an input stream carrying
// the X matrix then the Y matrix (row-major), writes them into the X/Y BRAM
// write ports, pulses mm_start, waits for mm_done, reads Z back through the Z
// BRAM read port and emits it as an output stream with a last marker.
//
// Ports
//   clock, reset            single rising-edge clock, async active-low reset
//   in_data/in_valid/in_ready      X then Y word stream
//   out_data/out_valid/out_ready/out_last   Z word stream, last on word N-1
//   mm_start / mm_done      compute start pulse / compute complete level
//   x_*/y_* (din, wr_addr, wr_en)  registered BRAM write ports
//   z_addr / z_dout         registered Z read address / read data (1 cycle)
//   dbg_state               current FSM state
//   cycle_count             WAIT-cycle counter (only with
//                           MATMUL_HOST_CYCLE_COUNT_EN defined)
//
// Handshake: a word moves on a rising edge where valid & ready are both high.
// A source holds data stable while valid is high and ready is low; valid
// never depends on ready.
// -----------------------------------------------------------------------------
module matmul_host #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 6,
   parameter int VECTOR_SIZE = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  mm_start,
   input  logic                  mm_done,
   output logic [DATA_WIDTH-1:0] x_din,
   output logic [ADDR_WIDTH-1:0] x_wr_addr,
   output logic                  x_wr_en,
   output logic [DATA_WIDTH-1:0] y_din,
   output logic [ADDR_WIDTH-1:0] y_wr_addr,
   output logic                  y_wr_en,
   output logic [ADDR_WIDTH-1:0] z_addr,
   input  logic [DATA_WIDTH-1:0] z_dout,
   output logic [2:0]            dbg_state
`ifdef MATMUL_HOST_CYCLE_COUNT_EN
   ,output logic [31:0]          cycle_count
`endif
);

   localparam int N  = VECTOR_SIZE * VECTOR_SIZE;
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LD_LAST = ADDR_WIDTH'(N - 1);
   localparam logic [CW-1:0]         RD_LAST = CW'(N - 1);
   localparam logic [CW-1:0]         RD_END  = CW'(N);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_X = 3'd1;
   localparam logic [2:0] S_LOAD_Y = 3'd2;
   localparam logic [2:0] S_FLUSH  = 3'd3;
   localparam logic [2:0] S_START  = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_DRAIN  = 3'd6;

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_wait_first;
   logic [DATA_WIDTH-1:0] r_x_din, r_y_din;
   logic [ADDR_WIDTH-1:0] r_x_wr_addr, r_y_wr_addr;
   logic                  r_x_wr_en, r_y_wr_en;

   // Read side: the counter is one bit wider than the address so that
   // "all N reads issued" is representable without wrapping back to 0.
   logic [CW-1:0]         r_rd_cnt;
   logic                  r_pend;
   logic                  r_pend_last;
   logic [DATA_WIDTH-1:0] r_fifo_d0, r_fifo_d1;
   logic                  r_fifo_l0, r_fifo_l1;
   logic                  r_wptr, r_rptr;
   logic [1:0]            r_count;

   logic w_load, w_accept, w_pop, w_room, w_issue, w_head_last, w_last_beat;

   assign w_load      = (r_state == S_LOAD_X) || (r_state == S_LOAD_Y);
   assign w_accept    = w_load && in_valid;
   assign w_pop       = (r_count != 2'd0) && out_ready;
   // A read may only issue if its data is guaranteed a FIFO slot when it
   // lands next cycle: occupancy + in-flight - pop must leave room.
   assign w_room      = ({1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_pop}) < 3'd2;
   assign w_issue     = (r_state == S_DRAIN) && (r_rd_cnt < RD_END) && w_room;
   assign w_head_last = r_rptr ? r_fifo_l1 : r_fifo_l0;
   assign w_last_beat = w_pop && w_head_last;

   assign in_ready  = w_load;
   assign mm_start  = (r_state == S_START);
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_rptr ? r_fifo_d1 : r_fifo_d0;
   assign out_last  = out_valid && w_head_last;
   assign x_din     = r_x_din;
   assign x_wr_addr = r_x_wr_addr;
   assign x_wr_en   = r_x_wr_en;
   assign y_din     = r_y_din;
   assign y_wr_addr = r_y_wr_addr;
   assign y_wr_en   = r_y_wr_en;
   assign z_addr    = r_rd_cnt[ADDR_WIDTH-1:0];
   assign dbg_state = r_state;

   // Control FSM and BRAM write ports.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_wait_first <= 1'b0;
         r_x_din      <= '0;
         r_y_din      <= '0;
         r_x_wr_addr  <= '0;
         r_y_wr_addr  <= '0;
         r_x_wr_en    <= 1'b0;
         r_y_wr_en    <= 1'b0;
      end else begin
         r_x_wr_en <= 1'b0;
         r_y_wr_en <= 1'b0;
         case (r_state)
            S_IDLE: r_state <= S_LOAD_X;
            S_LOAD_X, S_LOAD_Y: begin
               if (w_accept) begin
                  if (r_state == S_LOAD_X) begin
                     r_x_wr_en   <= 1'b1;
                     r_x_wr_addr <= r_cnt;
                     r_x_din     <= in_data;
                  end else begin
                     r_y_wr_en   <= 1'b1;
                     r_y_wr_addr <= r_cnt;
                     r_y_din     <= in_data;
                  end
                  if (r_cnt == LD_LAST) begin
                     r_cnt   <= '0;
                     r_state <= (r_state == S_LOAD_X) ? S_LOAD_Y : S_FLUSH;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            // Last Y write is on the BRAM port during this cycle.
            S_FLUSH: r_state <= S_START;
            S_START: begin
               r_state      <= S_WAIT;
               r_wait_first <= 1'b1;
            end
            // mm_done may still be high from the previous job; the first
            // WAIT cycle never counts as completion.
            S_WAIT: begin
               if (r_wait_first) begin
                  r_wait_first <= 1'b0;
               end else if (mm_done) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: if (w_last_beat) r_state <= S_LOAD_X;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Z readback: read issue, in-flight tracking and 2-entry output FIFO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rd_cnt    <= '0;
         r_pend      <= 1'b0;
         r_pend_last <= 1'b0;
         r_fifo_d0   <= '0;
         r_fifo_d1   <= '0;
         r_fifo_l0   <= 1'b0;
         r_fifo_l1   <= 1'b0;
         r_wptr      <= 1'b0;
         r_rptr      <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         if (w_last_beat) begin
            r_rd_cnt <= '0;
         end else if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
         end
         r_pend      <= w_issue;
         r_pend_last <= w_issue && (r_rd_cnt == RD_LAST);
         if (r_pend) begin
            if (r_wptr) begin
               r_fifo_d1 <= z_dout;
               r_fifo_l1 <= r_pend_last;
            end else begin
               r_fifo_d0 <= z_dout;
               r_fifo_l0 <= r_pend_last;
            end
            r_wptr <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
      end
   end

`ifdef MATMUL_HOST_CYCLE_COUNT_EN
   // Counts WAIT cycles of the most recent job, saturating.
   logic [31:0] r_cycle_count;
   assign cycle_count = r_cycle_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cycle_count <= '0;
      end else if (r_state == S_FLUSH) begin
         r_cycle_count <= '0;
      end else if ((r_state == S_WAIT) && (r_cycle_count != 32'hFFFF_FFFF)) begin
         r_cycle_count <= r_cycle_count + 32'd1;
      end
   end
`endif

endmodule
